// File: rtl/fflags_accum_ram.sv
// DEPTH x WIDTH exception-flag store with NW write ports, per-entry valid bits,
// optional OR-accumulation, entry clear, global flush and a bypassed registered read.
module fflags_accum_ram #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 5,
    parameter int NW    = 2,
    parameter int ACCUM = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NW-1:0]       W_en,
    input  logic [NW*AW-1:0]    W_addr,
    input  logic [NW*WIDTH-1:0] W_data,
    input  logic                R_en,
    input  logic [AW-1:0]       R_addr,
    output logic [WIDTH-1:0]    R_data,
    output logic                R_valid,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic                flush,
    output logic                any_valid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_next;
    logic             rd_hit;
    logic [WIDTH-1:0] rd_data_next;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Clear first, then ports in ascending order, so a higher port overwrites or
    // ORs on top of a lower one; flush discards everything computed this cycle.
    always_comb begin
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        mem_next   = mem;
        valid_next = valid;
        a          = '0;
        d          = '0;
        if (clr_en && in_range(clr_addr)) begin
            valid_next[clr_addr] = 1'b0;
        end
        for (int i = 0; i < NW; i++) begin
            a = W_addr[i*AW +: AW];
            d = W_data[i*WIDTH +: WIDTH];
            if (W_en[i] && in_range(a)) begin
                if (ACCUM != 0 && valid_next[a]) begin
                    mem_next[a] = mem_next[a] | d;
                end else begin
                    mem_next[a] = d;
                end
                valid_next[a] = 1'b1;
            end
        end
        if (flush) begin
            mem_next   = mem;
            valid_next = '0;
        end
    end

    always_comb begin
        rd_hit       = 1'b0;
        rd_data_next = '0;
        if (R_en && in_range(R_addr)) begin
            rd_hit = valid_next[R_addr];
        end
        if (rd_hit) begin
            rd_data_next = mem_next[R_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= '0;
            R_data  <= '0;
            R_valid <= 1'b0;
        end else begin
            valid   <= valid_next;
            R_valid <= R_en && rd_hit;
            if (R_en) begin
                R_data <= rd_data_next;
            end
        end
    end

    // Contents are never reset; valid bits gate every observable output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem <= mem_next;
        end
    end

    assign any_valid = |valid;

endmodule

// File: tb/tb_fflags_accum_ram.sv
// Directed self-checking bench: one ACCUM=1 and one ACCUM=0 instance share all stimulus.
module tb_fflags_accum_ram;

    localparam int DEPTH = 7;
    localparam int WIDTH = 5;
    localparam int NW    = 2;
    localparam int AW    = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic [NW-1:0]       w_en;
    logic [NW*AW-1:0]    w_addr;
    logic [NW*WIDTH-1:0] w_data;
    logic                r_en;
    logic [AW-1:0]       r_addr;
    logic                clr_en;
    logic [AW-1:0]       clr_addr;
    logic                flush;
    logic [WIDTH-1:0]    r_data_a, r_data_o;
    logic                r_valid_a, r_valid_o;
    logic                any_valid_a, any_valid_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fflags_accum_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NW(NW), .ACCUM(1)) dut_acc (
        .clock(clock), .reset(reset), .W_en(w_en), .W_addr(w_addr), .W_data(w_data),
        .R_en(r_en), .R_addr(r_addr), .R_data(r_data_a), .R_valid(r_valid_a),
        .clr_en(clr_en), .clr_addr(clr_addr), .flush(flush), .any_valid(any_valid_a)
    );

    fflags_accum_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NW(NW), .ACCUM(0)) dut_ovw (
        .clock(clock), .reset(reset), .W_en(w_en), .W_addr(w_addr), .W_data(w_data),
        .R_en(r_en), .R_addr(r_addr), .R_data(r_data_o), .R_valid(r_valid_o),
        .clr_en(clr_en), .clr_addr(clr_addr), .flush(flush), .any_valid(any_valid_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle();
        reset    = 1'b0;
        w_en     = '0;
        w_addr   = '0;
        w_data   = '0;
        r_en     = 1'b0;
        r_addr   = '0;
        clr_en   = 1'b0;
        clr_addr = '0;
        flush    = 1'b0;
    endtask

    // Commit the currently driven inputs at one posedge, then release them.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic write_port(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        w_en[p]                = 1'b1;
        w_addr[p*AW +: AW]     = a;
        w_data[p*WIDTH +: WIDTH] = d;
    endtask

    task automatic read_at(input logic [AW-1:0] a);
        r_en   = 1'b1;
        r_addr = a;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkOutput("reset_any_valid", 32'(any_valid_a), 32'd0);
        checkOutput("reset_r_valid", 32'(r_valid_a), 32'd0);
        checkOutput("reset_r_data", 32'(r_data_a), 32'd0);

        // Accumulate across two cycles
        write_port(0, 3'd2, 5'b00001);
        applyStimulus();
        checkOutput("acc_any_valid", 32'(any_valid_a), 32'd1);
        write_port(0, 3'd2, 5'b10000);
        applyStimulus();
        read_at(3'd2);
        applyStimulus();
        checkOutput("acc2_data", 32'(r_data_a), 32'b10001);
        checkOutput("acc2_valid", 32'(r_valid_a), 32'd1);
        checkOutput("ovw2_data", 32'(r_data_o), 32'b10000);

        // Same-cycle dual write to one address
        write_port(0, 3'd4, 5'b00100);
        write_port(1, 3'd4, 5'b01000);
        applyStimulus();
        read_at(3'd4);
        applyStimulus();
        checkOutput("dual_acc_data", 32'(r_data_a), 32'b01100);
        checkOutput("dual_ovw_data", 32'(r_data_o), 32'b01000);

        // R_en low: valid drops, data holds
        applyStimulus();
        checkOutput("hold_valid", 32'(r_valid_a), 32'd0);
        checkOutput("hold_data", 32'(r_data_a), 32'b01100);

        // Write-through bypass
        write_port(0, 3'd6, 5'b00011);
        read_at(3'd6);
        applyStimulus();
        checkOutput("bypass_data", 32'(r_data_a), 32'b00011);
        checkOutput("bypass_valid", 32'(r_valid_a), 32'd1);

        // Clear plus write same cycle: no OR with stale bits
        write_port(1, 3'd1, 5'b11000);
        applyStimulus();
        read_at(3'd1);
        applyStimulus();
        checkOutput("pre_clr_data", 32'(r_data_a), 32'b11000);
        clr_en   = 1'b1;
        clr_addr = 3'd1;
        write_port(0, 3'd1, 5'b00010);
        applyStimulus();
        read_at(3'd1);
        applyStimulus();
        checkOutput("clr_wr_data", 32'(r_data_a), 32'b00010);
        checkOutput("clr_wr_valid", 32'(r_valid_a), 32'd1);

        // Clear alone invalidates
        clr_en   = 1'b1;
        clr_addr = 3'd2;
        applyStimulus();
        read_at(3'd2);
        applyStimulus();
        checkOutput("clr_valid", 32'(r_valid_a), 32'd0);
        checkOutput("clr_data", 32'(r_data_a), 32'd0);

        // Out-of-range write and read are ignored
        write_port(0, 3'd7, 5'b11111);
        read_at(3'd7);
        applyStimulus();
        checkOutput("oor_valid", 32'(r_valid_a), 32'd0);
        checkOutput("oor_data", 32'(r_data_a), 32'd0);

        // Flush drops same-cycle write and read
        write_port(0, 3'd0, 5'b10101);
        read_at(3'd0);
        flush = 1'b1;
        applyStimulus();
        checkOutput("flush_valid", 32'(r_valid_a), 32'd0);
        checkOutput("flush_data", 32'(r_data_a), 32'd0);
        checkOutput("flush_any_valid", 32'(any_valid_a), 32'd0);
        checkOutput("flush_any_valid_ovw", 32'(any_valid_o), 32'd0);

        // Reset mid-run overrides same-cycle write and read
        write_port(0, 3'd3, 5'b00111);
        write_port(1, 3'd5, 5'b01010);
        applyStimulus();
        checkOutput("pre_rst_any_valid", 32'(any_valid_a), 32'd1);
        read_at(3'd3);
        applyStimulus();
        checkOutput("pre_rst_data", 32'(r_data_a), 32'b00111);
        reset = 1'b1;
        write_port(0, 3'd3, 5'b11111);
        read_at(3'd3);
        applyStimulus();
        checkOutput("rst_any_valid", 32'(any_valid_a), 32'd0);
        checkOutput("rst_r_valid", 32'(r_valid_a), 32'd0);
        checkOutput("rst_r_data", 32'(r_data_a), 32'd0);
        read_at(3'd3);
        applyStimulus();
        checkOutput("post_rst_valid", 32'(r_valid_a), 32'd0);
        checkOutput("post_rst_data", 32'(r_data_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
